pixel_frame_tx: RTL

Source end of the pixel-stream interface into the thresholding frame buffer. A host loads one SIZE x SIZE greyscale frame into local storage, then pulses start. The block then streams the frame in raster order, one pixel per cycle, on pix_out/en. It then asserts select and reads back the thresholded frame. It counts white (255) pixels and flags protocol errors. The block sits between the host/loader and the frame-buffer/threshold stage.

---
 rtl/pixel_frame_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_tx.sv
// pixel_frame_tx: holds one SIZE x SIZE greyscale frame loaded by the host.
// It streams the frame downstream in raster order, then collects the
// thresholded readback, counting white pixels and flagging protocol errors.
module pixel_frame_tx #(
    parameter int SIZE    = 10,
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              start,
    output logic [7:0]        pix_out,
    output logic              en,
    output logic              select,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       white_count,
    output logic              err
);

    localparam int NPIX   = SIZE * SIZE;
    localparam int IDX_W  = $clog2(NPIX + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(NPIX);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NPIX - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(NPIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_READBACK,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]        mem [NPIX];
    logic [IDX_W-1:0]  pix_idx;
    logic [IDX_W-1:0]  samp_idx;
    logic [WAIT_W-1:0] wait_cnt;

    logic consume;
    logic last_sample;
    logic timeout;

    // Host writes land only while idle; a simultaneous start, reset or an
    // address beyond the frame drops the write.
    always_ff @(posedge clk) begin
        if (reset && state == S_IDLE && wr_en && !start &&
            ({1'b0, wr_addr} < ADDR_LIM)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus readback sample qualification.
    always_comb begin
        state_next  = state;
        consume     = 1'b0;
        last_sample = 1'b0;
        timeout     = 1'b0;

        if (state == S_WAIT || state == S_READBACK) begin
            consume     = rx_ready;
            last_sample = rx_ready && (samp_idx == IDX_LAST);
        end
        if (state == S_WAIT && !rx_ready && wait_cnt == WAIT_LAST) begin
            timeout = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start) state_next = S_STREAM;
            end
            S_STREAM: begin
                if (pix_idx == IDX_END) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (last_sample)   state_next = S_DONE;
                else if (rx_ready) state_next = S_READBACK;
                else if (timeout)  state_next = S_DONE;
            end
            S_READBACK: begin
                if (last_sample) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered outputs, pixel/sample/wait counters and readback statistics.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_out     <= 8'h00;
            en          <= 1'b0;
            select      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            white_count <= 16'h0000;
            err         <= 1'b0;
            pix_idx     <= '0;
            samp_idx    <= '0;
            wait_cnt    <= '0;
        end else begin
            busy   <= (state_next != S_IDLE);
            done   <= (state_next == S_DONE);
            select <= (state_next == S_WAIT) || (state_next == S_READBACK);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        err         <= 1'b0;
                        white_count <= 16'h0000;
                        en          <= 1'b1;
                        pix_out     <= mem[0];
                        pix_idx     <= IDX_W'(1);
                        samp_idx    <= '0;
                        wait_cnt    <= '0;
                    end
                end
                S_STREAM: begin
                    if (pix_idx == IDX_END) begin
                        en      <= 1'b0;
                        pix_out <= 8'h00;
                    end else begin
                        pix_out <= mem[pix_idx];
                        pix_idx <= pix_idx + IDX_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!rx_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (timeout)   err <= 1'b1;
                end
                default: begin
                end
            endcase

            if (consume) begin
                samp_idx <= samp_idx + IDX_W'(1);
                if (rx_data == 8'hFF) begin
                    if (white_count != 16'hFFFF) white_count <= white_count + 16'd1;
                end else if (rx_data != 8'h00) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
